instruction_loader: RTL and testbench

//   Upstream feeder of the 512x32 instruction memory. Collects a program as a byte

---
 rtl/instruction_loader_pkg.sv | 28 ++
 rtl/instruction_loader_if.sv | 36 +++
 rtl/instruction_loader_word_assembler.sv | 44 ++++
 rtl/instruction_loader.sv | 130 +++++++++++++
 tb/tb_instruction_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, default widths and the
// end-of-program marker.
package instruction_loader_pkg;

    localparam int unsigned PC_WIDTH_DEF = 9;
    localparam int unsigned NB_WIDTH_DEF = 32;
    localparam int unsigned NB_BYTE_DEF  = 8;

    localparam logic [NB_WIDTH_DEF-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    localparam int unsigned BYTES_PER_WORD = NB_WIDTH_DEF / NB_BYTE_DEF;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BYTE_CNT_WIDTH = cnt_width(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRecv,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and memory-write bus of the instruction loader.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
    parameter int unsigned NB_WIDTH = NB_WIDTH_DEF,
    parameter int unsigned NB_BYTE  = NB_BYTE_DEF
);

    logic                rx_valid;
    logic [NB_BYTE-1:0]  rx_data;
    logic                rx_ready;
    logic                write_enable;
    logic [PC_WIDTH-1:0] address;
    logic [NB_WIDTH-1:0] write_data;

    // Master: byte source / memory side. Slave: the loader itself.
    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  write_enable,
        input  address,
        input  write_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output write_enable,
        output address,
        output write_data
    );

endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs little-endian stream bytes into one instruction word; flags the byte that
// completes the word.
module word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int unsigned NB_WIDTH = NB_WIDTH_DEF,
    parameter int unsigned NB_BYTE  = NB_BYTE_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_byte_valid,
    input  logic [NB_BYTE-1:0]  i_byte,
    output logic [NB_WIDTH-1:0] o_word,
    output logic                o_word_ready
);

    localparam int unsigned BPW = NB_WIDTH / NB_BYTE;
    localparam int unsigned CW  = cnt_width(BPW);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0]       r_byte_cnt;
    logic [NB_WIDTH-1:0] r_word;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (i_byte_valid) begin
            for (int k = 0; k < BPW; k++) begin
                if (r_byte_cnt == CW'(k)) begin
                    r_word[k*NB_BYTE +: NB_BYTE] <= i_byte;
                end
            end
            // Wrapping to 0 here leaves the counter ready for the next word.
            r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + CNT_ONE;
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_byte_valid && (r_byte_cnt == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program into instruction memory from address 0 until HALT or the
// last slot, and can sweep the whole memory to zero.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned          NB_WIDTH  = NB_WIDTH_DEF,
    parameter int unsigned          NB_BYTE   = NB_BYTE_DEF,
    parameter logic [NB_WIDTH-1:0]  HALT_WORD = HALT_WORD_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_clear,
    instruction_loader_if.slave   bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_full,
    output logic [PC_WIDTH:0]     o_word_count
);

    localparam logic [PC_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [PC_WIDTH-1:0] ADDR_ONE  = PC_WIDTH'(1);
    localparam logic [PC_WIDTH:0]   WC_ONE    = (PC_WIDTH + 1)'(1);

    state_e              r_state;
    state_e              w_state_d;
    logic [PC_WIDTH-1:0] r_addr;
    logic [PC_WIDTH-1:0] w_addr_d;
    logic [PC_WIDTH:0]   r_word_count;
    logic [PC_WIDTH:0]   w_word_count_d;
    logic                r_full;
    logic                w_full_d;

    logic                w_accept;
    logic                w_asm_clear;
    logic                w_word_ready;
    logic [NB_WIDTH-1:0] w_word;

    assign w_accept = (r_state == StRecv) && bus.rx_valid;

    word_assembler #(
        .NB_WIDTH (NB_WIDTH),
        .NB_BYTE  (NB_BYTE)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_asm_clear),
        .i_byte_valid (w_accept),
        .i_byte       (bus.rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_word_count <= '0;
            r_full       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_addr       <= w_addr_d;
            r_word_count <= w_word_count_d;
            r_full       <= w_full_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_addr_d       = r_addr;
        w_word_count_d = r_word_count;
        w_full_d       = r_full;
        w_asm_clear    = 1'b0;

        unique case (r_state)
            StIdle, StDone: begin
                // Clear wins over start when both pulse together.
                if (i_clear) begin
                    w_state_d = StClear;
                    w_addr_d  = '0;
                end else if (i_start) begin
                    w_state_d      = StRecv;
                    w_addr_d       = '0;
                    w_word_count_d = '0;
                    w_full_d       = 1'b0;
                    w_asm_clear    = 1'b1;
                end
            end
            StClear: begin
                if (r_addr == LAST_ADDR) begin
                    w_state_d = StIdle;
                end else begin
                    w_addr_d = r_addr + ADDR_ONE;
                end
            end
            StRecv: begin
                if (w_word_ready) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                w_word_count_d = r_word_count + WC_ONE;
                if (w_word == HALT_WORD) begin
                    w_state_d = StDone;
                end else if (r_addr == LAST_ADDR) begin
                    w_state_d = StDone;
                    w_full_d  = 1'b1;
                end else begin
                    w_state_d = StRecv;
                    w_addr_d  = r_addr + ADDR_ONE;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign bus.rx_ready     = (r_state == StRecv);
    assign bus.write_enable = (r_state == StClear) || (r_state == StWrite);
    assign bus.address      = r_addr;
    assign bus.write_data   = (r_state == StClear) ? '0 : w_word;

    assign o_busy       = (r_state == StClear) || (r_state == StRecv) || (r_state == StWrite);
    assign o_done       = (r_state == StDone);
    assign o_full       = r_full;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader: a reference model queues expected
// memory writes and a negedge monitor checks every write strobe against that queue.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clr;
    logic       busy;
    logic       done;
    logic       full;
    logic [9:0] wc;

    instruction_loader_if bus ();

    instruction_loader dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_clear      (clr),
        .bus          (bus),
        .o_busy       (busy),
        .o_done       (done),
        .o_full       (full),
        .o_word_count (wc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks      = 0;
    int  failures    = 0;
    int  writes_seen = 0;
    int  exp_wc;
    bit  exp_full;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.write_enable === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                         bus.address, bus.write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.address), 64'(e.addr));
                check("wr_data", 64'(bus.write_data), 64'(e.data));
            end
        end
    end

    // Reference model: words land at 0,1,2.. until HALT (inclusive) or the last slot.
    function automatic int model_load(input logic [31:0] words[$]);
        int n = 0;
        exp_full = 1'b0;
        foreach (words[i]) begin
            wr_t e;
            if (n == DEPTH) break;
            e.addr = 9'(n);
            e.data = words[i];
            exp_q.push_back(e);
            n++;
            if (words[i] == HALT) break;
            if (n == DEPTH) exp_full = 1'b1;
        end
        exp_wc = n;
        return n;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout: got ready=%b expected 1 within 50 cycles",
                     bus.rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit hold);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[k*8 +: 8]);
            if (k == 3) begin
                check("we_after_4th_byte", 64'(bus.write_enable), 64'd1);
                check("ready_low_in_write", 64'(bus.rx_ready), 64'd0);
            end
            if (!hold && $urandom_range(0, 3) == 0) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load(input logic [31:0] words[$], input bit hold, input string tag);
        int n;
        int base = writes_seen;
        n = model_load(words);
        pulse_start();
        for (int i = 0; i < n; i++) send_word(words[i], hold);
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_word_count"}, 64'(wc), 64'(exp_wc));
        check({tag, "_full"}, 64'(full), 64'(exp_full));
        check({tag, "_strobes"}, 64'(writes_seen - base), 64'(n));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_word_count"}, 64'(wc), 64'd0);
        check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
        check({tag, "_we"}, 64'(bus.write_enable), 64'd0);
        check({tag, "_addr"}, 64'(bus.address), 64'd0);
        check({tag, "_wdata"}, 64'(bus.write_data), 64'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst          = 1'b1;
        start        = 1'b0;
        clr          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    initial begin
        logic [31:0] words[$];
        int          n;

        // Reset
        do_reset(2);
        check_idle_zero("reset");

        // Basic two-word load
        words = '{32'h0020_0013, HALT};
        load(words, 1'b0, "load");

        // Valid held high throughout
        words = '{32'h0000_0001, 32'h0000_0002, HALT};
        load(words, 1'b1, "backpressure");

        // Fill every slot with non-HALT words
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back(32'(i));
        load(words, 1'b1, "full");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            check("full_no_accept", 64'(bus.rx_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        check("full_done_held", 64'(done), 64'd1);

        // Clear sweep, start pulsed with it and again mid-sweep
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) begin
            wr_t e;
            e.addr = 9'(i);
            e.data = 32'h0;
            exp_q.push_back(e);
        end
        clr   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clr   = 1'b0;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            start = (n == 100);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("clear_busy_cycles", 64'(n), 64'(DEPTH));
        check("clear_queue_empty", 64'(exp_q.size()), 64'd0);
        check("clear_then_idle_ready", 64'(bus.rx_ready), 64'd0);
        check("clear_then_idle_done", 64'(done), 64'd0);

        // Randomized loads, HALT sometimes mid-list, restarting from DONE
        for (int t = 0; t < 6; t++) begin
            int len = $urandom_range(1, 12);
            words.delete();
            for (int i = 0; i < len; i++) words.push_back(rand_word());
            if ($urandom_range(0, 1) == 1) words[$urandom_range(0, len - 1)] = HALT;
            words.push_back(HALT);
            load(words, ($urandom_range(0, 1) == 1), "random");
        end

        // Abort mid-word, then a fresh one-word load
        words = '{rand_word(), rand_word(), HALT};
        void'(model_load(words[0:1]));
        pulse_start();
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        send_byte(8'h5A);
        send_byte(8'hC3);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("abort");
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        words = '{HALT};
        load(words, 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
